truth_table_sweeper: RTL

//  Reads back the truth table of a combinational logic block: drives every input

---
 rtl/truth_table_sweeper.sv | 133 +++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps an N_IN-input combinational block through every input
// row, samples its output after a settle delay and builds the Cello hex code.
// Optional glitch detection is compiled in with `define TT_SWEEP_GLITCH_CHECK_EN.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  localparam int W            = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    expect_code,
  output logic [N_IN-1:0] drv_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    code,
  output logic            code_valid,
  output logic [1:0]      state_dbg,
  output logic            match
`ifdef TT_SWEEP_GLITCH_CHECK_EN
  ,
  output logic            glitch,
  output logic [N_IN-1:0] glitch_row
`endif
);

  // Handshake: start is a level request seen only in IDLE; the request is taken on
  // the edge where state==IDLE && start, and anything asserted at other times is dropped.
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] ROW_LAST = '1;

  state_t          state, state_nxt;
  logic [N_IN-1:0] row;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;
  logic            accept;

  assign accept    = (state == IDLE) && start;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy      = 1'b1;
        state_nxt = (row == ROW_LAST) ? DONE : SETTLE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row r lands in bit W-1-r, which is simply the bitwise inverse of r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_in     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      match      <= 1'b0;
      row        <= '0;
      cnt        <= '0;
      exp_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_q      <= expect_code;
          row        <= '0;
          drv_in     <= '0;
          cnt        <= '0;
          code       <= '0;
          code_valid <= 1'b0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        SAMPLE: begin
          code[~row] <= dut_out;
          if (row != ROW_LAST) begin
            row    <= row + 1'b1;
            drv_in <= row + 1'b1;
            cnt    <= '0;
          end
        end
        DONE: begin
          code_valid <= 1'b1;
          match      <= (code == exp_q);
        end
        default: ;
      endcase
    end
  end

`ifdef TT_SWEEP_GLITCH_CHECK_EN
  logic dut_q;

  // dut_q holds the output seen in the last SETTLE cycle when SAMPLE compares it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_q      <= 1'b0;
      glitch     <= 1'b0;
      glitch_row <= '0;
    end else begin
      dut_q <= dut_out;
      if (accept) begin
        glitch     <= 1'b0;
        glitch_row <= '0;
      end else if (state == SAMPLE && dut_q != dut_out && !glitch) begin
        glitch     <= 1'b1;
        glitch_row <= row;
      end
    end
  end
`endif

endmodule
